// File: rtl/led_pkg.sv
`timescale 1ns/1ps
// led_pkg: shared types and constants for the LED pattern generator.
//   led_mode_t : display mode encoding (matches the 2-bit mode input)
//   PWM_W      : width of the brightness input and the PWM counter
//                (only used when LED_PWM_EN is defined)
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_TOGGLE = 2'd3
  } led_mode_t;

  localparam int PWM_W = 4;

endpackage

// File: rtl/tick_prescaler.sv
`timescale 1ns/1ps
// tick_prescaler: step-rate divider for the LED pattern generator.
//   clk  : system clock
//   rst  : asynchronous active-high reset, clears the count
//   en   : count enable; when low the count holds and tick is 0
//   clr  : synchronous clear; returns the count to 0 and suppresses tick
//   tick : combinational step strobe, high on the enabled cycle whose
//          edge wraps the count from DIV-1 back to 0
// The owner registers whatever it updates on tick, so its registered
// outputs change in the cycle after the count wraps.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A one-bit counter still works for DIV=1: LAST is 0, so every enabled
  // cycle wraps.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  assign tick = en && !clr && (count_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
`timescale 1ns/1ps
// led_pattern_gen: LED driver with a step-rate prescaler and four modes
// (static, binary count, bouncing scan, alternating toggle).
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   en        : run enable; low freezes the prescaler and pattern state
//   mode      : requested mode, captured on mode_load
//   mode_load : single-cycle pulse capturing mode and pattern; it also
//               reinitialises the pattern state and clears the prescaler
//   pattern   : pattern captured on mode_load
//   bright    : (LED_PWM_EN only) brightness, duty = bright/16
//   led       : registered LED drive
//   tick      : one-cycle pulse per step, coincident with the new led value
//   mode_cur  : currently active mode
// Optional feature macro: LED_PWM_EN (adds bright and a free-running PWM
// counter that gates the led output).
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int               LED_W      = 8,
  parameter int               CLK_HZ     = 50000000,
  parameter int               STEP_HZ    = 4,
  parameter logic [LED_W-1:0] STATIC_PAT = LED_W'('h55)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             mode_load,
  input  logic [LED_W-1:0] pattern,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] bright,
`endif
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic [1:0]       mode_cur
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;

  generate
    if (TICK_DIV < 1) begin : g_bad_div
      $error("led_pattern_gen: CLK_HZ/STEP_HZ must be at least 1");
    end
  endgenerate

  localparam int PW = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(LED_W - 1);

  logic step;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (mode_load),
    .tick (step)
  );

  led_mode_t        mode_reg,  mode_next;
  logic [LED_W-1:0] pat_reg,   pat_next;
  logic [LED_W-1:0] cnt_reg,   cnt_next;
  logic [PW-1:0]    pos_reg,   pos_next;
  logic             down_reg,  down_next;   // scan direction, 1 = towards bit 0
  logic             phase_reg, phase_next;
  logic [LED_W-1:0] val_next;               // unmasked pattern value
  logic [LED_W-1:0] led_reg;
  logic             tick_reg;

  // Next-state logic. mode_load wins over a coincident step (the prescaler
  // also drops its strobe when cleared).
  always_comb begin
    mode_next  = mode_reg;
    pat_next   = pat_reg;
    cnt_next   = cnt_reg;
    pos_next   = pos_reg;
    down_next  = down_reg;
    phase_next = phase_reg;

    if (mode_load) begin
      mode_next  = led_mode_t'(mode);
      pat_next   = pattern;
      cnt_next   = '0;
      pos_next   = '0;
      down_next  = 1'b0;
      phase_next = 1'b0;
    end else if (step) begin
      case (mode_reg)
        MODE_COUNT:  cnt_next = cnt_reg + 1'b1;
        MODE_SCAN: begin
          // Turn around on reaching an end so the end position is shown once.
          if (LED_W > 1) begin
            if (!down_reg) begin
              if (pos_reg == POS_LAST) begin
                down_next = 1'b1;
                pos_next  = pos_reg - 1'b1;
              end else begin
                pos_next  = pos_reg + 1'b1;
              end
            end else begin
              if (pos_reg == '0) begin
                down_next = 1'b0;
                pos_next  = pos_reg + 1'b1;
              end else begin
                pos_next  = pos_reg - 1'b1;
              end
            end
          end
        end
        MODE_TOGGLE: phase_next = ~phase_reg;
        default: ;
      endcase
    end

    // The displayed value is a pure function of the next state, so led
    // tracks the state with no extra latency.
    case (mode_next)
      MODE_STATIC: val_next = pat_next;
      MODE_COUNT:  val_next = cnt_next;
      MODE_SCAN:   val_next = LED_W'(1) << pos_next;
      MODE_TOGGLE: val_next = phase_next ? ~pat_next : pat_next;
      default:     val_next = pat_next;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= MODE_STATIC;
      pat_reg   <= STATIC_PAT;
      cnt_reg   <= '0;
      pos_reg   <= '0;
      down_reg  <= 1'b0;
      phase_reg <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      mode_reg  <= mode_next;
      pat_reg   <= pat_next;
      cnt_reg   <= cnt_next;
      pos_reg   <= pos_next;
      down_reg  <= down_next;
      phase_reg <= phase_next;
      tick_reg  <= step;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_reg;
  logic [PWM_W-1:0] pwm_next;
  logic             pwm_on;

  // Gate with the count the PWM register will hold after this edge, so the
  // registered led and pwm_reg stay aligned.
  assign pwm_next = pwm_reg + 1'b1;
  assign pwm_on   = (pwm_next < bright);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_reg <= '0;
      led_reg <= STATIC_PAT;
    end else begin
      pwm_reg <= pwm_next;
      led_reg <= val_next & {LED_W{pwm_on}};
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_reg <= STATIC_PAT;
    end else begin
      led_reg <= val_next;
    end
  end
`endif

  assign led      = led_reg;
  assign tick     = tick_reg;
  assign mode_cur = mode_reg;

endmodule

// File: tb/tb_led_pattern_gen.sv
`timescale 1ns/1ps
// tb_led_pattern_gen: directed self-checking bench for led_pattern_gen
// with CLK_HZ=16, STEP_HZ=4 (four cycles per step), LED_W=8.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       mode_load;
  logic [7:0] pattern;
  logic [7:0] led;
  logic       tick;
  logic [1:0] mode_cur;
`ifdef LED_PWM_EN
  logic [3:0] bright;
`endif

  int checks = 0;
  int errors = 0;
  int gap;

  logic [7:0] scan_exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04,
                                8'h02, 8'h01, 8'h02, 8'h04};

  always #5 clk = ~clk;

  led_pattern_gen #(
    .LED_W      (8),
    .CLK_HZ     (16),
    .STEP_HZ    (4),
    .STATIC_PAT (8'h55)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .mode_load (mode_load),
    .pattern   (pattern),
`ifdef LED_PWM_EN
    .bright    (bright),
`endif
    .led       (led),
    .tick      (tick),
    .mode_cur  (mode_cur)
  );

`ifdef LED_PWM_EN
  int pwm_model;
  always @(posedge clk or posedge rst) begin
    if (rst) pwm_model <= 0;
    else     pwm_model <= (pwm_model + 1) % 16;
  end

  function automatic logic [7:0] exp_led(input logic [7:0] v);
    return v & {8{pwm_model < int'(bright)}};
  endfunction
`else
  function automatic logic [7:0] exp_led(input logic [7:0] v);
    return v;
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until tick is seen (bounded); n = cycles taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 12);
    check("wait_tick", 32'(tick), 32'd1);
  endtask

  task automatic load(input logic [1:0] m, input logic [7:0] p);
    mode      = m;
    pattern   = p;
    mode_load = 1'b1;
    step();
    mode_load = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    mode      = 2'd0;
    mode_load = 1'b0;
    pattern   = 8'h00;
`ifdef LED_PWM_EN
    bright    = 4'd15;
`endif
    #2;
    check("reset_led", 32'(led), 32'h55);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_mode", 32'(mode_cur), 32'd0);
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;

    // Static: tick every 4th cycle, led constant.
    for (int i = 1; i <= 8; i++) begin
      step();
      check("static_tick", 32'(tick), (i % 4 == 0) ? 32'd1 : 32'd0);
      check("static_led", 32'(led), 32'(exp_led(8'h55)));
    end

    // COUNT, including the FF->00 wrap after 256 ticks.
    load(2'd1, 8'h00);
    check("count_init_led", 32'(led), 32'(exp_led(8'h00)));
    check("count_mode", 32'(mode_cur), 32'd1);
    check("count_load_tick", 32'(tick), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(gap);
      check("count_gap", 32'(gap), 32'd4);
      check("count_led", 32'(led), 32'(exp_led(8'(k))));
    end
    for (int k = 4; k <= 256; k++) begin
      wait_tick(gap);
      if (k == 255) check("count_ff", 32'(led), 32'(exp_led(8'hFF)));
    end
    check("count_wrap", 32'(led), 32'(exp_led(8'h00)));

    // SCAN bounce.
    load(2'd2, 8'h3C);
    check("scan_init_led", 32'(led), 32'(exp_led(8'h01)));
    for (int k = 0; k < 16; k++) begin
      wait_tick(gap);
      check("scan_led", 32'(led), 32'(exp_led(scan_exp[k])));
    end

    // TOGGLE, then freeze with en low.
    load(2'd3, 8'hA5);
    check("toggle_init_led", 32'(led), 32'(exp_led(8'hA5)));
    for (int k = 0; k < 3; k++) begin
      wait_tick(gap);
      check("toggle_led", 32'(led), 32'(exp_led((k % 2 == 0) ? 8'h5A : 8'hA5)));
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("freeze_tick", 32'(tick), 32'd0);
      check("freeze_led", 32'(led), 32'(exp_led(8'h5A)));
    end
    en = 1'b1;
    wait_tick(gap);
    check("unfreeze_gap", 32'(gap), 32'd4);
    check("unfreeze_led", 32'(led), 32'(exp_led(8'hA5)));

    // mode_load coinciding with a wrap: tick dropped, prescaler restarts.
    step();
    step();
    step();
    check("pre_collision_tick", 32'(tick), 32'd0);
    load(2'd1, 8'h00);
    check("collision_tick", 32'(tick), 32'd0);
    check("collision_led", 32'(led), 32'(exp_led(8'h00)));
    check("collision_mode", 32'(mode_cur), 32'd1);
    wait_tick(gap);
    check("collision_gap", 32'(gap), 32'd4);
    check("collision_next_led", 32'(led), 32'(exp_led(8'h01)));

    // Asynchronous reset in the middle of SCAN.
    load(2'd2, 8'h00);
    wait_tick(gap);
    wait_tick(gap);
    check("midscan_led", 32'(led), 32'(exp_led(8'h04)));
    rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'h55);
    check("async_rst_mode", 32'(mode_cur), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_tick(gap);
    check("post_rst_gap", 32'(gap), 32'd4);
    check("post_rst_led", 32'(led), 32'(exp_led(8'h55)));

`ifdef LED_PWM_EN
    // Duty over 16 consecutive cycles equals bright.
    load(2'd0, 8'hFF);
    for (int b = 0; b <= 15; b += 15) begin
      int on_cnt;
      bright = 4'(b);
      on_cnt = 0;
      for (int c = 0; c < 16; c++) begin
        step();
        if (led == 8'hFF) on_cnt++;
      end
      check("pwm_duty", 32'(on_cnt), 32'(b));
    end
    begin
      int on_cnt;
      bright = 4'd8;
      on_cnt = 0;
      for (int c = 0; c < 16; c++) begin
        step();
        if (led == 8'hFF) on_cnt++;
      end
      check("pwm_duty_half", 32'(on_cnt), 32'd8);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED driver that generalises the board's fixed constant-pattern LED output.
- Runs a step-rate prescaler and four selectable display modes: static, binary count, bouncing scan, and alternating toggle.
- Sits between top-level control logic and the onboard LED pins, in the 50 MHz clk domain.

Parameters:
- LED_W, 8, number of LEDs driven.
- CLK_HZ, 50000000, input clock frequency.
- STEP_HZ, 4, pattern step rate. TICK_DIV = CLK_HZ/STEP_HZ, which must be at least 1 (elaboration-time check).
- STATIC_PAT, 'h55, pattern loaded at reset, LED_W bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock (clk); rst is asynchronous and active-high.
- en  in  1  run enable. When low, the prescaler and pattern state freeze.
- mode  in  2  requested mode (0 STATIC, 1 COUNT, 2 SCAN, 3 TOGGLE).
- mode_load  in  1  single-cycle pulse. Captures mode and pattern.
- pattern  in  LED_W  pattern captured on mode_load.
- led  out  LED_W  registered LED drive.
- tick  out  1  one-cycle pulse at each step.
- mode_cur  out  2  currently active mode.

Behaviour:
- Reset (async, rst=1): led=STATIC_PAT, pat_reg=STATIC_PAT, mode_cur=0, tick=0, prescaler=0, cnt=0, pos=0, dir=up, phase=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1.
  - Produces tick=1 for exactly one cycle in the cycle after the count wraps.
  - TICK_DIV=1 gives tick every enabled cycle.
  - en=0 holds the count; tick=0.
- All state updates on the tick condition. led is registered: the new value appears in the cycle after the tick-causing edge, coincident with tick=1.
- STATIC: led=pat_reg; ticks have no visible effect.
- COUNT:
  - LED_W-bit counter increments per tick; led=cnt.
  - Wraps from all-ones to 0.
- SCAN:
  - One-hot led=1<<pos.
  - pos sequence 0,1,..,LED_W-1,LED_W-2,..,0,1,...
  - Direction reverses at the ends; the end positions do not repeat.
  - LED_W=1: led stays at 1.
- TOGGLE: phase toggles per tick; led=pat_reg when phase=0, ~pat_reg when phase=1.
- mode_load=1 in cycle N:
  - mode_cur<=mode, pat_reg<=pattern.
  - cnt, pos, dir and phase reinitialise; prescaler clears to 0.
  - led shows the new mode's initial value at N+1: STATIC/TOGGLE→pattern, COUNT→0, SCAN→1.
- mode_load has priority over a coincident tick. That tick is dropped and tick output stays 0 the following cycle.
- mode_load is accepted regardless of en.
- rst asserted mid-sequence returns everything to reset values immediately. The first tick after release comes TICK_DIV enabled cycles later.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - Adds input port bright [3:0].
  - A free-running 4-bit pwm_cnt runs whenever the block is out of reset.
  - led output = pattern value AND (pwm_cnt < bright), per bit.
  - bright=0 gives all off; bright=15 gives 15/16 duty.
  - pwm_cnt resets to 0.
- Undefined: no bright port, no pwm_cnt; led = pattern value directly.

Decomposition:
- Package led_pkg:
  - typedef led_mode_t (2-bit enum MODE_STATIC=0, MODE_COUNT=1, MODE_SCAN=2, MODE_TOGGLE=3).
  - Constant PWM_W=4.
- One sub-module, tick_prescaler:
  - Parameter DIV.
  - Ports clk, rst, en, clr, tick.
- The pattern state machine stays in led_pattern_gen.

Test Plan:
- Bench parameters: CLK_HZ=16, STEP_HZ=4 (TICK_DIV=4), LED_W=8.
- Reset/static: release rst, en=1 → led=8'h55 constant, tick every 4th cycle, mode_cur=0.
- COUNT wrap: mode_load mode=1 → led=00 next cycle, then 01,02,… per tick. Force 256 ticks → FF→00 wrap.
- SCAN bounce: mode=2 → led sequence 01,02,04,…,80,40,…,01,02. There is no repeated 80 or 01.
- TOGGLE: mode=3, pattern=8'hA5 → led A5,5A,A5 per tick. Drop en for 10 cycles → led frozen, no tick.
- Collision/reset: mode_load on a tick cycle → no tick pulse, new mode initial value, next tick 4 cycles later. Assert rst mid-SCAN → led=55 asynchronously.
- LED_PWM_EN defined, STATIC 8'hFF: bright=0 → led=00 always; bright=8 → led=FF for 8 of every 16 cycles; bright=15 → 15 of 16.
